// File: rtl/fetch_stage_pkg.sv
// Shared widths, constants and helpers for the LEGv8 fetch stage.
package fetch_stage_pkg;

    localparam int unsigned WORD      = 64;
    localparam int unsigned INSTR_LEN = 32;
    localparam int unsigned CNT_W     = 32;

    localparam logic [WORD-1:0] PC_STEP       = 64'd4;
    // Clears the two byte-offset bits so a redirect always lands on a word.
    localparam logic [WORD-1:0] PC_ALIGN_MASK = ~64'h3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register: synchronous reset to RESET_PC, load-enabled update.
module pc_register
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [WORD-1:0] pc_next,
    output logic [WORD-1:0] pc
);

    // Hold the PC unless loaded; reset takes priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples pre-edge values.
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, IF/ID register and fetch counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [WORD-1:0]      branch_target,
    input  logic [INSTR_LEN-1:0] imem_data,
    output logic [WORD-1:0]      imem_addr,
    output logic [WORD-1:0]      if_id_pc,
    output logic [INSTR_LEN-1:0] if_id_instr,
    output logic                 if_id_valid,
    output logic [CNT_W-1:0]     fetch_count
);

    logic [WORD-1:0] pc;
    logic [WORD-1:0] pc_plus_step;
    logic [WORD-1:0] pc_next;
    logic            pc_load;

    // Sequential PC plus one word; the adder wraps naturally at 2^64.
    assign pc_plus_step = pc + PC_STEP;

    // A redirect must move the PC even when decode is stalling on wrong-path work.
    assign pc_load = !stall || branch_taken;

    // Next-PC mux: redirect target (word aligned) or the sequential address.
    always_comb begin
        // NOTE: default assignment first so no path leaves pc_next unassigned (no latch).
        pc_next = pc_plus_step;
        if (branch_taken) begin
            pc_next = branch_target & PC_ALIGN_MASK;
        end
    end

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk     (clk),
        .reset   (reset),
        .load    (pc_load),
        .pc_next (pc_next),
        .pc      (pc)
    );

    assign imem_addr = pc;

    // IF/ID register and delivered-instruction counter: reset > redirect > stall > fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else if (branch_taken) begin
            // Wrong-path instruction is squashed; its payload is left as-is.
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_pc    <= pc;
            if_id_instr <= imem_data;
            if_id_valid <= 1'b1;
            fetch_count <= sat_inc(fetch_count);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: stimulus pushes hand-computed
// post-edge expectations, a monitor pops and compares after every edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] imem_data;
    logic [63:0] imem_addr;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_data     (imem_data),
        .imem_addr     (imem_addr),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Asynchronous instruction memory model.
    always_comb begin
        case (imem_addr)
            64'h0:   imem_data = 32'hA0;
            64'h4:   imem_data = 32'hA1;
            64'h8:   imem_data = 32'hA2;
            64'hC:   imem_data = 32'hA3;
            64'h10:  imem_data = 32'hA4;
            64'h100: imem_data = 32'hB0;
            64'h104: imem_data = 32'hB1;
            default: imem_data = {16'hDEAD, imem_addr[15:0]};
        endcase
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs and record what the DUT must show after the edge.
    task automatic step(input logic rst, input logic stl, input logic br, input logic [63:0] tgt,
                        input logic [63:0] e_addr, input logic [63:0] e_pc, input logic [31:0] e_instr,
                        input logic e_valid, input logic [31:0] e_count);
        exp_t e;
        reset         = rst;
        stall         = stl;
        branch_taken  = br;
        branch_target = tgt;
        e.addr  = e_addr;
        e.pc    = e_pc;
        e.instr = e_instr;
        e.valid = e_valid;
        e.count = e_count;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare the DUT state shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("imem_addr",   imem_addr,   e.addr);
                check("if_id_pc",    if_id_pc,    e.pc);
                check("if_id_instr", {32'h0, if_id_instr}, {32'h0, e.instr});
                check("if_id_valid", {63'h0, if_id_valid}, {63'h0, e.valid});
                check("fetch_count", {32'h0, fetch_count}, {32'h0, e.count});
            end
        end
    end

    // Stimulus: directed vectors, expected values computed by hand.
    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        @(negedge clk);
        //   rst stl br  target                  addr                    if_id_pc                instr         v  cnt
        step(1, 0, 0, 64'h0,                  64'h0,                  64'h0,                  32'h0,        0, 0);
        step(0, 0, 0, 64'h0,                  64'h4,                  64'h0,                  32'hA0,       1, 1);
        step(0, 0, 0, 64'h0,                  64'h8,                  64'h4,                  32'hA1,       1, 2);
        step(0, 1, 0, 64'h0,                  64'h8,                  64'h4,                  32'hA1,       1, 2);
        step(0, 1, 0, 64'h0,                  64'h8,                  64'h4,                  32'hA1,       1, 2);
        step(0, 0, 0, 64'h0,                  64'hC,                  64'h8,                  32'hA2,       1, 3);
        step(0, 0, 0, 64'h0,                  64'h10,                 64'hC,                  32'hA3,       1, 4);
        step(0, 0, 1, 64'h103,                64'h100,                64'hC,                  32'hA3,       0, 4);
        step(0, 0, 0, 64'h0,                  64'h104,                64'h100,                32'hB0,       1, 5);
        step(0, 1, 1, 64'h10,                 64'h10,                 64'h100,                32'hB0,       0, 5);
        step(0, 1, 0, 64'h0,                  64'h10,                 64'h100,                32'hB0,       0, 5);
        step(0, 0, 0, 64'h0,                  64'h14,                 64'h10,                 32'hA4,       1, 6);
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10,                32'hA4,       0, 6);
        step(0, 0, 0, 64'h0,                  64'h0,                  64'hFFFF_FFFF_FFFF_FFFC, 32'hDEADFFFC, 1, 7);
        step(0, 0, 0, 64'h0,                  64'h4,                  64'h0,                  32'hA0,       1, 8);
        step(1, 1, 1, 64'h200,                64'h0,                  64'h0,                  32'h0,        0, 0);
        step(0, 0, 0, 64'h0,                  64'h4,                  64'h0,                  32'hA0,       1, 1);
        stall = 1'b1; branch_taken = 1'b0;
        stim_done = 1'b1;
    end

    // Completion with a bounded wait for the scoreboard to drain.
    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || !stim_done) begin
            failures++;
            $display("FAIL drain: %0d expectations left, stim_done=%0d, required 0 and 1", exp_q.size(), stim_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
